// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - run-ahead instruction fetch with a DEPTH-entry queue toward decode
// Issues sequential bus reads from an internal fetch PC; redirect flushes and retargets.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enabled,
    output logic                     request_enable,
    output logic                     mode,
    output logic [31:0]              addr,
    output logic [31:0]              wdata,
    output logic [3:0]               wstrb,
    input  logic                     response_enable,
    input  logic [31:0]              data,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [31:0]              instr_raw,
    output logic [31:0]              instr_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int             PW         = $clog2(DEPTH);
    localparam logic [PW:0]    FULL_COUNT = (PW+1)'(DEPTH);
    localparam logic [PW-1:0]  PTR_ONE    = PW'(1);
    localparam logic [PW:0]    CNT_ONE    = (PW+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [31:0]    r_fetch_pc;
    logic [31:0]    r_req_pc;
    logic           r_req_en;
    logic [31:0]    r_mem_pc  [DEPTH];
    logic [31:0]    r_mem_raw [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [PW:0]    r_count;
    logic           w_issue;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_valid;

    assign w_full  = (r_count == FULL_COUNT);
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && instr_ready && !redirect_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Only one access is ever outstanding, so a non-full queue always has room for it.
                if (enabled && !redirect_valid && !w_full) begin
                    w_issue     = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (response_enable) begin
                    w_push      = !redirect_valid;
                    w_state_nxt = ST_IDLE;
                end else if (redirect_valid) begin
                    w_state_nxt = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (response_enable) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_req_en   <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_req_en <= w_issue;
            if (w_issue) begin
                r_req_pc <= r_fetch_pc;
            end
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + PC_STEP;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_ONE;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_ONE;
                    2'b01:   r_count <= r_count - CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]  <= r_req_pc;
            r_mem_raw[r_wr_ptr] <= data;
        end
    end

    assign request_enable = r_req_en;
    assign mode           = 1'b0;
    assign addr           = r_req_pc;
    assign wdata          = '0;
    assign wstrb          = '0;
    assign count          = r_count;
    assign instr_valid    = w_valid;
    assign instr_raw      = w_valid ? r_mem_raw[r_rd_ptr] : '0;
    assign instr_pc       = w_valid ? r_mem_pc[r_rd_ptr]  : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized scoreboard bench for fetch_queue
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h100;
    localparam logic [31:0] PC_STEP  = 32'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enabled;
    logic        request_enable;
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        response_enable;
    logic [31:0] data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_raw;
    logic [31:0] instr_pc;
    logic [2:0]  count;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
        .clk(clk), .rst(rst), .enabled(enabled),
        .request_enable(request_enable), .mode(mode), .addr(addr),
        .wdata(wdata), .wstrb(wstrb),
        .response_enable(response_enable), .data(data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_raw(instr_raw), .instr_pc(instr_pc), .count(count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory: answers each request after lat_lo..lat_hi cycles, even across a reset.
    int          lat_cnt = 0;
    int          lat_lo  = 1;
    int          lat_hi  = 1;
    logic [31:0] pend_addr = '0;

    initial begin
        response_enable = 1'b0;
        data            = '0;
    end

    always @(negedge clk) begin
        response_enable = 1'b0;
        data            = $urandom;
        if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
                response_enable = 1'b1;
                data            = mem_word(pend_addr);
            end
        end
        if (request_enable === 1'b1) begin
            pend_addr = addr;
            lat_cnt   = $urandom_range(lat_hi, lat_lo);
        end
    end

    // Reference model and scoreboard: queue of expected {pc, word} entries.
    logic [31:0] qp[$];
    logic [31:0] qr[$];
    logic        m_out    = 1'b0;
    logic        m_squash = 1'b0;
    logic [31:0] m_pc     = RESET_PC;
    logic [31:0] m_oaddr  = '0;
    logic        p_valid  = 1'b0;
    logic [31:0] p_pc     = '0;
    logic [31:0] p_raw    = '0;

    initial begin
        bit exp_issue;
        bit push_now;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                qp.delete();
                qr.delete();
                m_out    = 1'b0;
                m_squash = 1'b0;
                m_pc     = RESET_PC;
                check("rst_req_en", request_enable, 0);
                check("rst_addr", addr, 0);
            end else begin
                exp_issue = enabled && !redirect_valid && !m_out && (qp.size() < DEPTH);
                push_now  = 1'b0;
                if (m_out && response_enable) begin
                    push_now = !m_squash && !redirect_valid;
                    m_out    = 1'b0;
                end else if (m_out && redirect_valid) begin
                    m_squash = 1'b1;
                end
                if (redirect_valid) begin
                    qp.delete();
                    qr.delete();
                    m_pc = redirect_pc & 32'hFFFF_FFFC;
                end else begin
                    if (p_valid && instr_ready) begin
                        if (qp.size() == 0) begin
                            check("pop_on_empty_model", p_valid, 0);
                        end else begin
                            check("pop_pc", p_pc, qp[0]);
                            check("pop_raw", p_raw, qr[0]);
                            void'(qp.pop_front());
                            void'(qr.pop_front());
                        end
                    end
                    if (push_now) begin
                        qp.push_back(m_oaddr);
                        qr.push_back(mem_word(m_oaddr));
                    end
                end
                check("req_en", request_enable, exp_issue);
                if (exp_issue) begin
                    check("req_addr", addr, m_pc);
                    m_oaddr  = m_pc;
                    m_out    = 1'b1;
                    m_squash = 1'b0;
                    m_pc     = m_pc + PC_STEP;
                end
            end
            check("count", count, qp.size());
            check("instr_valid", instr_valid, qp.size() != 0);
            check("instr_pc", instr_pc, (qp.size() != 0) ? qp[0] : 32'h0);
            check("instr_raw", instr_raw, (qr.size() != 0) ? qr[0] : 32'h0);
            check("mode", mode, 0);
            check("wdata", wdata, 0);
            check("wstrb", wstrb, 0);
            p_valid = instr_valid;
            p_pc    = instr_pc;
            p_raw   = instr_raw;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req(input string name);
        int k = 0;
        while (request_enable !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check(name, request_enable, 1);
    endtask

    initial begin
        rst            = 1'b1;
        enabled        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        cyc(2);
        rst         = 1'b0;
        enabled     = 1'b1;
        instr_ready = 1'b1;
        cyc(40);

        instr_ready = 1'b0;
        cyc(30);
        check("bp_full", count, DEPTH);
        instr_ready = 1'b1;
        cyc(1);
        instr_ready = 1'b0;
        check("bp_one_pop", count, DEPTH - 1);
        cyc(10);
        check("bp_refill", count, DEPTH);
        instr_ready = 1'b1;
        lat_lo = 3;
        lat_hi = 3;
        cyc(6);

        wait_req("redir_wait_req");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2002;
        cyc(1);
        redirect_valid = 1'b0;
        cyc(20);

        lat_lo = 1;
        lat_hi = 1;
        cyc(4);
        wait_req("simul_wait_req");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3000;
        cyc(1);
        redirect_valid = 1'b0;
        cyc(10);

        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        cyc(1);
        redirect_valid = 1'b0;
        cyc(12);

        instr_ready = 1'b0;
        cyc(15);
        enabled     = 1'b0;
        instr_ready = 1'b1;
        cyc(15);
        check("drain_empty", count, 0);
        enabled = 1'b1;

        lat_lo = 3;
        lat_hi = 3;
        cyc(4);
        wait_req("rst_wait_req");
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(10);

        lat_lo = 1;
        lat_hi = 4;
        for (int i = 0; i < 800; i++) begin
            enabled        = ($urandom_range(9, 0) != 0);
            instr_ready    = ($urandom_range(9, 0) < 6);
            redirect_valid = ($urandom_range(19, 0) == 0);
            redirect_pc    = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(7, 0)))
                                                        : 32'($urandom);
            rst            = ($urandom_range(149, 0) == 0);
            cyc(1);
        end
        rst            = 1'b0;
        redirect_valid = 1'b0;
        cyc(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
